// File: rtl/btn_pkg.sv
// Shared state encoding and counter-width helper for the button debouncer.
package btn_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    StReleased    = 2'd0,
    StPressWait   = 2'd1,
    StPressed     = 2'd2,
    StReleaseWait = 2'd3
  } btn_state_e;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: polarity, 2-FF synchroniser, debounce FSM, hold/repeat timer.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned HOLD_CYCLES     = 1000,
  parameter int unsigned REPEAT_CYCLES   = 0,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sample_en,
  input  logic button_in,
  output logic btn_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HW = cnt_width(HOLD_CYCLES + REPEAT_CYCLES);

  localparam logic [DW-1:0] DcntCommit = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HoldVal    = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] RepeatVal  = HW'(HOLD_CYCLES + REPEAT_CYCLES);

  logic [1:0]    sync_q;
  logic          s;
  btn_state_e    state_q, state_d;
  logic [DW-1:0] dcnt_q, dcnt_d, dcnt_inc;
  logic [HW-1:0] hcnt_q, hcnt_d, hcnt_inc;
  logic          hold_sat, hold_hit, repeat_hit;
  logic          btn_q, btn_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;

  // Polarity first so the synchroniser always carries "1 = pressed"; runs every clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], button_in ^ ACTIVE_LOW};
    end
  end

  assign s = sync_q[1];

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StReleased;
      dcnt_q    <= '0;
      hcnt_q    <= '0;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      hcnt_q    <= hcnt_d;
      btn_q     <= btn_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  // Hold timer decode: saturate without repeat, otherwise fold back to HOLD on each repeat.
  always_comb begin
    dcnt_inc   = dcnt_q + 1'b1;
    hcnt_inc   = hcnt_q + 1'b1;
    hold_sat   = (REPEAT_CYCLES == 0) && (hcnt_q == HoldVal);
    hold_hit   = !hold_sat && (hcnt_inc == HoldVal);
    repeat_hit = (REPEAT_CYCLES > 0) && (hcnt_inc == RepeatVal);
  end

  // Next-state and counter update; everything advances only on enabled samples.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    hcnt_d  = hcnt_q;
    if (sample_en) begin
      unique case (state_q)
        StReleased: begin
          if (s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              state_d = StPressed;
              dcnt_d  = '0;
              hcnt_d  = '0;
            end else begin
              state_d = StPressWait;
              dcnt_d  = DW'(1);
            end
          end
        end
        StPressWait: begin
          if (!s) begin
            state_d = StReleased;
            dcnt_d  = '0;
          end else if (dcnt_inc == DcntCommit) begin
            state_d = StPressed;
            dcnt_d  = '0;
            hcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_inc;
          end
        end
        StPressed: begin
          if (s) begin
            if (repeat_hit) begin
              hcnt_d = HoldVal;
            end else if (!hold_sat) begin
              hcnt_d = hcnt_inc;
            end
          end else if (DEBOUNCE_CYCLES == 1) begin
            state_d = StReleased;
            hcnt_d  = '0;
          end else begin
            state_d = StReleaseWait;
            dcnt_d  = DW'(1);
          end
        end
        StReleaseWait: begin
          // Hold timer stays frozen so a bounce does not restart it.
          if (s) begin
            state_d = StPressed;
            dcnt_d  = '0;
          end else if (dcnt_inc == DcntCommit) begin
            state_d = StReleased;
            dcnt_d  = '0;
            hcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_inc;
          end
        end
        default: begin
          state_d = StReleased;
          dcnt_d  = '0;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  // Output decode from the transition being taken; pulses last one clk by construction.
  always_comb begin
    btn_d     = (state_d == StPressed) || (state_d == StReleaseWait);
    press_d   = (state_d == StPressed) &&
                ((state_q == StReleased) || (state_q == StPressWait));
    release_d = (state_d == StReleased) &&
                ((state_q == StPressed) || (state_q == StReleaseWait));
    long_d    = sample_en && (state_q == StPressed) && s && (hold_hit || repeat_hit);
  end

  assign btn_state     = btn_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: rtl/button_debouncer_multi.sv
// N-channel button debouncer: one independent debounce_channel per button pin.
module button_debouncer_multi
  import btn_pkg::*;
#(
  parameter int unsigned       NUM_CH          = 4,
  parameter int unsigned       DEBOUNCE_CYCLES = 20,
  parameter int unsigned       HOLD_CYCLES     = 1000,
  parameter int unsigned       REPEAT_CYCLES   = 0,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW      = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_en,
  input  logic [NUM_CH-1:0] button_in,
  output logic [NUM_CH-1:0] btn_state,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] long_pulse
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW[i])
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample_en    (sample_en),
      .button_in    (button_in[i]),
      .btn_state    (btn_state[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i])
    );
  end

endmodule
